// File: rtl/cram_pkg.sv
// Shared definitions for the CRAM diagnostic loader: word geometry, DIAG_FN codes,
// loader states and the chunk <-> word bit mapping (bit n of 0:83 is vector index 83-n).
package cram_pkg;

  localparam int CRAM_W   = 84;
  localparam int CHUNK_W  = 21;
  localparam int N_CHUNKS = 4;

  localparam logic [2:0] FN_LDADR  = 3'd0;
  localparam logic [2:0] FN_LDCH0  = 3'd1;
  localparam logic [2:0] FN_LDCH1  = 3'd2;
  localparam logic [2:0] FN_LDCH2  = 3'd3;
  localparam logic [2:0] FN_LDCH3  = 3'd4;
  localparam logic [2:0] FN_WRITE  = 3'd5;
  localparam logic [2:0] FN_READ   = 3'd6;
  localparam logic [2:0] FN_CLRERR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RDW  = 2'd2
  } state_t;

  // Low vector index of chunk k. Chunk 0 holds CRAM bits 0..20, the most significant end,
  // so DIAG_DATA[20] lands on the lowest-numbered CRAM bit of the chunk.
  function automatic int chunk_lo(input logic [1:0] k);
    return (N_CHUNKS - 1 - int'(k)) * CHUNK_W;
  endfunction

  function automatic logic [CRAM_W-1:0] chunk_insert(input logic [CRAM_W-1:0]  word,
                                                     input logic [1:0]         k,
                                                     input logic [CHUNK_W-1:0] data);
    logic [CRAM_W-1:0] w;
    w = word;
    w[chunk_lo(k) +: CHUNK_W] = data;
    return w;
  endfunction

  function automatic logic [CHUNK_W-1:0] chunk_extract(input logic [CRAM_W-1:0] word,
                                                       input logic [1:0]        k);
    return word[chunk_lo(k) +: CHUNK_W];
  endfunction

endpackage

// File: rtl/cram_loader.sv
// Diagnostic CRAM loader: assembles 84-bit words from 21-bit chunks, writes them to the
// microcode store and reads words back for verification.
module cram_loader
  import cram_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int RD_LAT  = 1,
  parameter int AUTOINC = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                DIAG_STROBE,
  input  logic [2:0]          DIAG_FN,
  input  logic [CHUNK_W-1:0]  DIAG_DATA,
  input  logic [1:0]          DIAG_RSEL,
  output logic                BUSY,
  output logic                ACK,
  output logic                ERR,
  output logic                OWN,
  output logic                CRAM_WE,
  output logic [ADDR_W-1:0]   CRAM_ADDR,
  output logic [CRAM_W-1:0]   CRAM_DIN,
  input  logic [CRAM_W-1:0]   CRAM_DOUT,
  output logic [CRAM_W-1:0]   RDDATA,
  output logic [CHUNK_W-1:0]  RDCHUNK
);

  localparam int CNT_W = 2;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr;
  logic [CRAM_W-1:0]   din;
  logic [CRAM_W-1:0]   rddata;
  logic [CNT_W-1:0]    cnt;
  logic                ack;
  logic                err;
  logic                rd_done;
  logic [1:0]          ld_sel;

  // LDCH0..3 are codes 1..4; the low two bits minus one give the chunk index.
  assign ld_sel  = DIAG_FN[1:0] - 2'd1;
  assign rd_done = (state == ST_RDW) && (cnt == CNT_W'(1));

  // NOTE: state_nx gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (DIAG_STROBE && DIAG_FN == FN_WRITE) state_nx = ST_WR;
        if (DIAG_STROBE && DIAG_FN == FN_READ)  state_nx = ST_RDW;
      end
      ST_WR:   state_nx = ST_IDLE;
      ST_RDW:  if (rd_done) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr   <= '0;
      din    <= '0;
      rddata <= '0;
      cnt    <= '0;
      ack    <= 1'b0;
      err    <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (DIAG_STROBE) begin
            case (DIAG_FN)
              FN_LDADR: begin
                addr <= DIAG_DATA[ADDR_W-1:0];
                ack  <= 1'b1;
              end
              FN_LDCH0, FN_LDCH1, FN_LDCH2, FN_LDCH3: begin
                din <= chunk_insert(din, ld_sel, DIAG_DATA);
                ack <= 1'b1;
              end
              FN_CLRERR: begin
                err <= 1'b0;
                ack <= 1'b1;
              end
              FN_READ: cnt <= CNT_W'(RD_LAT);
              default: ;
            endcase
          end
        end
        ST_WR: begin
          ack <= 1'b1;
          if (AUTOINC != 0) addr <= addr + ADDR_W'(1);
        end
        ST_RDW: begin
          cnt <= cnt - CNT_W'(1);
          if (rd_done) begin
            rddata <= CRAM_DOUT;
            ack    <= 1'b1;
            if (AUTOINC != 0) addr <= addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
      // A strobe during an operation is dropped; only the sticky flag records it.
      if (DIAG_STROBE && state != ST_IDLE) err <= 1'b1;
    end
  end

  assign BUSY      = (state != ST_IDLE);
  assign OWN       = (state != ST_IDLE);
  assign CRAM_WE   = (state == ST_WR);
  assign ACK       = ack;
  assign ERR       = err;
  assign CRAM_ADDR = addr;
  assign CRAM_DIN  = din;
  assign RDDATA    = rddata;
  assign RDCHUNK   = chunk_extract(rddata, DIAG_RSEL);

endmodule

// File: tb/tb_cram_loader.sv
// Directed bench for cram_loader with a small cram_mem model (RD_LAT=2 read pipeline).
module tb_cram_loader;

  localparam int RD_LAT_TB = 2;
  localparam logic [83:0] WORD =
    {21'h1FFFFF, 21'h000001, 21'h155555, 21'h0AAAAA};

  logic        clk = 1'b0;
  logic        reset;
  logic        DIAG_STROBE;
  logic [2:0]  DIAG_FN;
  logic [20:0] DIAG_DATA;
  logic [1:0]  DIAG_RSEL;
  logic        BUSY, ACK, ERR, OWN, CRAM_WE;
  logic [11:0] CRAM_ADDR;
  logic [83:0] CRAM_DIN, CRAM_DOUT, RDDATA;
  logic [20:0] RDCHUNK;

  int checks = 0;
  int errors = 0;

  logic [83:0] mem [0:4095];
  logic [83:0] rd_pipe [0:2];
  int          wr_count = 0;
  logic [11:0] wr_addr_q [$];

  always #5 clk = ~clk;

  cram_loader #(.ADDR_W(12), .RD_LAT(RD_LAT_TB), .AUTOINC(1)) dut (
    .clk(clk), .reset(reset),
    .DIAG_STROBE(DIAG_STROBE), .DIAG_FN(DIAG_FN), .DIAG_DATA(DIAG_DATA),
    .DIAG_RSEL(DIAG_RSEL),
    .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .OWN(OWN),
    .CRAM_WE(CRAM_WE), .CRAM_ADDR(CRAM_ADDR), .CRAM_DIN(CRAM_DIN),
    .CRAM_DOUT(CRAM_DOUT), .RDDATA(RDDATA), .RDCHUNK(RDCHUNK)
  );

  // cram_mem model: a write is whatever CRAM_WE shows at a rising edge
  always @(posedge clk) begin
    if (CRAM_WE) begin
      mem[CRAM_ADDR] <= CRAM_DIN;
      wr_count = wr_count + 1;
      wr_addr_q.push_back(CRAM_ADDR);
    end
    rd_pipe[0] <= mem[CRAM_ADDR];
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign CRAM_DOUT = rd_pipe[RD_LAT_TB-1];

  // One strobe cycle; returns just after the following falling edge (cycle after strobe).
  task automatic cmd(input logic [2:0] fn, input logic [20:0] data);
    @(negedge clk);
    DIAG_STROBE = 1'b1; DIAG_FN = fn; DIAG_DATA = data;
    @(negedge clk);
    DIAG_STROBE = 1'b0;
  endtask

  // n = number of clocks from the strobe cycle to the cycle where ACK is seen (bounded).
  task automatic wait_ack(output int n);
    n = 1;
    while (!ACK && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; DIAG_STROBE = 1'b1; DIAG_FN = 3'd5; DIAG_DATA = 21'h1FFFFF; DIAG_RSEL = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({BUSY, ACK, ERR, OWN, CRAM_WE} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {BUSY, ACK, ERR, OWN, CRAM_WE});
    end
    checks++;
    if (CRAM_ADDR !== 12'd0 || CRAM_DIN !== 84'd0 || RDDATA !== 84'd0 || RDCHUNK !== 21'd0) begin
      errors++; $display("FAIL reset_regs: addr=%h din=%h rd=%h chunk=%h want all 0",
                         CRAM_ADDR, CRAM_DIN, RDDATA, RDCHUNK);
    end
    reset = 1'b0; DIAG_STROBE = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_count !== 0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_no_write: writes=%0d busy=%b want 0 0", wr_count, BUSY);
    end
  endtask

  task automatic test_write;
    int n;
    cmd(3'd0, 21'o1234);
    checks++;
    if (ACK !== 1'b1 || CRAM_ADDR !== 12'o1234) begin
      errors++; $display("FAIL ldadr: ack=%b addr=%o want 1 1234", ACK, CRAM_ADDR);
    end
    cmd(3'd1, 21'h1FFFFF);
    cmd(3'd2, 21'h000001);
    cmd(3'd3, 21'h155555);
    cmd(3'd4, 21'h0AAAAA);
    checks++;
    if (CRAM_DIN !== WORD) begin
      errors++; $display("FAIL assemble: got %h want %h", CRAM_DIN, WORD);
    end
    cmd(3'd5, 21'd0);
    checks++;
    if ({CRAM_WE, OWN, BUSY, ACK} !== 4'b1110 || CRAM_ADDR !== 12'o1234) begin
      errors++; $display("FAIL write_cycle: we/own/busy/ack=%b addr=%o want 1110 1234",
                         {CRAM_WE, OWN, BUSY, ACK}, CRAM_ADDR);
    end
    @(negedge clk);
    checks++;
    if ({ACK, CRAM_WE, BUSY} !== 3'b100 || CRAM_ADDR !== 12'o1235) begin
      errors++; $display("FAIL write_ack: ack/we/busy=%b addr=%o want 100 1235",
                         {ACK, CRAM_WE, BUSY}, CRAM_ADDR);
    end
    @(negedge clk);
    checks++;
    if (ACK !== 1'b0) begin
      errors++; $display("FAIL ack_width: ack=%b want 0", ACK);
    end
    checks++;
    if (wr_count !== 1 || wr_addr_q[0] !== 12'o1234 || mem[12'o1234] !== WORD) begin
      errors++; $display("FAIL write_mem: writes=%0d data=%h want 1 %h",
                         wr_count, mem[12'o1234], WORD);
    end
    n = 0;
  endtask

  task automatic test_read;
    int n;
    cmd(3'd0, 21'o1234);
    cmd(3'd6, 21'd0);
    checks++;
    if ({BUSY, OWN, CRAM_WE} !== 3'b110) begin
      errors++; $display("FAIL read_busy: busy/own/we=%b want 110", {BUSY, OWN, CRAM_WE});
    end
    wait_ack(n);
    checks++;
    if (n !== RD_LAT_TB + 1) begin
      errors++; $display("FAIL read_latency: ack after %0d clocks want %0d", n, RD_LAT_TB + 1);
    end
    checks++;
    if (RDDATA !== WORD || CRAM_ADDR !== 12'o1235) begin
      errors++; $display("FAIL read_data: rd=%h addr=%o want %h 1235", RDDATA, CRAM_ADDR, WORD);
    end
    DIAG_RSEL = 2'd2; #1;
    checks++;
    if (RDCHUNK !== 21'h155555) begin
      errors++; $display("FAIL rdchunk2: got %h want 155555", RDCHUNK);
    end
    DIAG_RSEL = 2'd0; #1;
    checks++;
    if (RDCHUNK !== 21'h1FFFFF) begin
      errors++; $display("FAIL rdchunk0: got %h want 1fffff", RDCHUNK);
    end
    DIAG_RSEL = 2'd3; #1;
    checks++;
    if (RDCHUNK !== 21'h0AAAAA) begin
      errors++; $display("FAIL rdchunk3: got %h want 0aaaaa", RDCHUNK);
    end
  endtask

  task automatic test_wrap;
    int n;
    int base;
    base = wr_count;
    cmd(3'd0, 21'o7777);
    cmd(3'd5, 21'd0);
    wait_ack(n);
    cmd(3'd5, 21'd0);
    wait_ack(n);
    checks++;
    if (wr_count !== base + 2 || wr_addr_q[base] !== 12'o7777 || wr_addr_q[base+1] !== 12'o0000) begin
      errors++; $display("FAIL wrap_addrs: writes=%0d want %0d, sequence 7777 then 0000",
                         wr_count - base, 2);
    end
    checks++;
    if (mem[12'o7777] !== WORD || mem[12'o0000] !== WORD) begin
      errors++; $display("FAIL wrap_data: m7777=%h m0=%h want %h", mem[12'o7777], mem[0], WORD);
    end
    checks++;
    if (ERR !== 1'b0 || CRAM_ADDR !== 12'o0001) begin
      errors++; $display("FAIL wrap_err: err=%b addr=%o want 0 0001", ERR, CRAM_ADDR);
    end
  endtask

  task automatic test_busy_err;
    int n;
    cmd(3'd0, 21'o1234);
    @(negedge clk);
    DIAG_STROBE = 1'b1; DIAG_FN = 3'd6; DIAG_DATA = 21'd0;
    @(negedge clk);
    DIAG_FN = 3'd1; DIAG_DATA = 21'h000123;
    @(negedge clk);
    DIAG_STROBE = 1'b0;
    n = 2;
    while (!ACK && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== RD_LAT_TB + 1 || RDDATA !== WORD) begin
      errors++; $display("FAIL busy_read: ack after %0d rd=%h want %0d %h",
                         n, RDDATA, RD_LAT_TB + 1, WORD);
    end
    checks++;
    if (ERR !== 1'b1 || CRAM_DIN !== WORD) begin
      errors++; $display("FAIL busy_err: err=%b din=%h want 1 %h", ERR, CRAM_DIN, WORD);
    end
    cmd(3'd7, 21'd0);
    checks++;
    if (ACK !== 1'b1 || ERR !== 1'b0) begin
      errors++; $display("FAIL clrerr: ack=%b err=%b want 1 0", ACK, ERR);
    end
  endtask

  task automatic test_chunk_iso;
    cmd(3'd2, 21'h0ABCDE);
    checks++;
    if (CRAM_DIN !== {21'h1FFFFF, 21'h0ABCDE, 21'h155555, 21'h0AAAAA}) begin
      errors++; $display("FAIL chunk_iso: got %h want %h", CRAM_DIN,
                         {21'h1FFFFF, 21'h0ABCDE, 21'h155555, 21'h0AAAAA});
    end
  endtask

  task automatic test_reset_abort;
    int base;
    cmd(3'd0, 21'o55);
    base = wr_count;
    @(negedge clk);
    DIAG_STROBE = 1'b1; DIAG_FN = 3'd5; DIAG_DATA = 21'd0;
    @(posedge clk);
    #1 reset = 1'b1; DIAG_STROBE = 1'b0;
    @(negedge clk);
    checks++;
    if ({BUSY, ACK, ERR, OWN, CRAM_WE} !== 5'b0 || CRAM_ADDR !== 12'd0 ||
        CRAM_DIN !== 84'd0 || RDDATA !== 84'd0) begin
      errors++; $display("FAIL abort_regs: flags=%b addr=%o din=%h rd=%h want all 0",
                         {BUSY, ACK, ERR, OWN, CRAM_WE}, CRAM_ADDR, CRAM_DIN, RDDATA);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_count !== base || BUSY !== 1'b0 || ACK !== 1'b0) begin
      errors++; $display("FAIL abort_no_write: writes=%0d busy=%b ack=%b want %0d 0 0",
                         wr_count, BUSY, ACK, base);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_wrap;
    test_busy_err;
    test_chunk_iso;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cram_loader.md
Name: cram_loader

Overview:
- Diagnostic-side writer and reader for the 84-bit microcode store (cram_mem, address CRADR[11:0], data bits 0:83).
- Accepts front-end diagnostic strobes carrying 21-bit chunks.
- Assembles a full CRAM word from the chunks, then writes it to the memory port.
- Can read a word back for verification; the result is presented as a word and as 21-bit chunks.

Parameters:
- ADDR_W, 12, CRAM address width.
- RD_LAT, 1, cram_mem read latency in clocks (1..3).
- AUTOINC, 1, if 1, address post-increments after each WRITE and READ.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- DIAG_STROBE  in  1  one-cycle command strobe.
- DIAG_FN  in  3  command: 0 LDADR, 1..4 LDCH0..3, 5 WRITE, 6 READ, 7 CLRERR.
- DIAG_DATA  in  21  command operand.
- DIAG_RSEL  in  2  readback chunk select.
- BUSY  out  1  loader not idle.
- ACK  out  1  one-cycle pulse on command completion.
- ERR  out  1  sticky: strobe received while BUSY.
- OWN  out  1  loader owns the cram_mem port. The external address mux selects CRAM_ADDR when OWN=1.
- CRAM_WE  out  1  write enable to cram_mem.
- CRAM_ADDR  out  ADDR_W  current address register.
- CRAM_DIN  out  84  assembled word, bits 0:83.
- CRAM_DOUT  in  84  cram_mem read data.
- RDDATA  out  84  captured readback word.
- RDCHUNK  out  21  RDDATA chunk selected by DIAG_RSEL (combinational).

Behaviour:
- Reset (async, active-high) clears everything to 0: state, address, data, ERR, ACK, BUSY, OWN, CRAM_WE, RDDATA.
- Reset asserted mid-operation aborts the operation. CRAM_WE drops immediately; no partial word is written.

Chunk mapping:
- Chunk k occupies CRAM bits 21k .. 21k+20.
- DIAG_DATA[20] maps to the lowest-numbered bit of the chunk (bit 21k); DIAG_DATA[0] maps to bit 21k+20.
- The same mapping applies in reverse for RDCHUNK.

States:
- IDLE: BUSY=0, OWN=0. Accepts DIAG_STROBE.
  - LDADR: address <= DIAG_DATA[ADDR_W-1:0]; ACK the next cycle; stay IDLE.
  - LDCHn: chunk n of CRAM_DIN <= DIAG_DATA; ACK the next cycle; stay IDLE.
  - CLRERR: ERR <= 0; ACK the next cycle.
  - WRITE -> WR.
  - READ -> RDW; latency counter <= RD_LAT.
- WR (one cycle): OWN=1, BUSY=1, CRAM_WE=1, CRAM_ADDR=address, CRAM_DIN=assembled word. Exit to IDLE with ACK=1. Address increments on exit when AUTOINC=1.
- RDW: OWN=1, BUSY=1. Address held stable. Counter decrements each clock.
  - When the counter reaches 0, RDDATA <= CRAM_DOUT and the block goes to IDLE with ACK=1.
  - Address increments on exit when AUTOINC=1.
  - READ-to-ACK latency is RD_LAT+1 clocks after the strobe.

Timing and boundary rules:
- WRITE strobe to CRAM_WE: 1 clock. ACK follows in the next clock.
- Address increment wraps modulo 2^ADDR_W (4095 -> 0). No error is raised on wrap.
- A strobe while BUSY is ignored and sets ERR. The in-progress operation completes normally.
- CLRERR in the same cycle as a busy strobe cannot occur, because CLRERR is itself ignored while BUSY.
- The assembled word persists across WRITEs, so repeated writes of the same pattern need no reload.
- Loading a chunk never touches the other chunks.
- ACK is exactly one cycle wide and never asserts during reset.
- An unused DIAG_FN value is unreachable, because all 8 codes are defined.

Decomposition:
- Shared package cram_pkg holds:
  - CRAM_W=84, CHUNK_W=21, N_CHUNKS=4.
  - The DIAG_FN code constants.
  - The loader state enum (IDLE, WR, RDW).
  - A function that maps chunk index to bit range.
- No sub-module is required. The chunk insert and extract logic is a function in cram_pkg, reused by RDCHUNK.

Test Plan:
1. Reset with DIAG_STROBE held high -> all outputs 0, and no CRAM_WE is seen after reset deasserts.
2. LDADR 0o1234, LDCH0..3 = 0x1FFFFF, 0x000001, 0x155555, 0x0AAAAA, then WRITE -> one CRAM_WE pulse at addr 0o1234 with the corresponding 84-bit word. ACK follows the next cycle, and CRAM_ADDR becomes 0o1235.
3. LDADR 0o1234, READ with RD_LAT=2 (memory model returns the written word) -> ACK 3 clocks after the strobe. RDDATA matches the word, and RDCHUNK for RSEL=2 reads 0x155555.
4. LDADR 0o7777, WRITE, WRITE -> writes land at 0o7777 then 0o0000 (wrap). ERR stays 0.
5. READ, then a second strobe (LDCH0) one cycle later -> ERR=1, chunk 0 is unchanged, and the read completes. A later CLRERR gives ERR=0 with ACK.
6. Reset asserted in the cycle after a WRITE strobe -> CRAM_WE never asserts, and the state returns to IDLE with all registers 0.
